// File: rtl/ldst_pkg.sv
// Shared definitions for the LD/ST lane scheduler: FSM states, ldst field constants
// and packet field offsets ({addr,reg,data,space,size}, size in the LSBs).
package ldst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } ldst_state_e;

  localparam logic [1:0] LDST_SPACE_GLOBAL = 2'd0;
  localparam logic [1:0] LDST_SPACE_SHARED = 2'd1;
  localparam logic [1:0] LDST_SPACE_LOCAL  = 2'd2;
  localparam logic [1:0] LDST_SPACE_CONST  = 2'd3;

  localparam logic [1:0] LDST_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] LDST_SIZE_HALF  = 2'd1;
  localparam logic [1:0] LDST_SIZE_WORD  = 2'd2;
  localparam logic [1:0] LDST_SIZE_DWORD = 2'd3;

  function automatic int pktWidth(input int addrW, input int regW, input int dataW,
                                  input int spaceW, input int sizeW);
    return addrW + regW + dataW + spaceW + sizeW;
  endfunction

  function automatic int offSpace(input int sizeW);
    return sizeW;
  endfunction

  function automatic int offData(input int spaceW, input int sizeW);
    return sizeW + spaceW;
  endfunction

  function automatic int offReg(input int dataW, input int spaceW, input int sizeW);
    return sizeW + spaceW + dataW;
  endfunction

  function automatic int offAddr(input int regW, input int dataW, input int spaceW,
                                 input int sizeW);
    return sizeW + spaceW + dataW + regW;
  endfunction

endpackage

// File: rtl/ldst_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the least significant set bit and
// whether any bit was set.
module ldst_prio_enc #(
  parameter int LANES    = 4,
  parameter int LANE_LOG = 2
) (
  input  logic [LANES-1:0]    vec,
  output logic [LANE_LOG-1:0] idx,
  output logic                found
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = LANE_LOG'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldst_lane_sched.sv
// Serialises one warp-wide LD/ST batch onto a scalar memory port, lowest active lane
// first, and gathers tagged load responses into a single vector writeback.
module ldst_lane_sched
  import ldst_pkg::*;
#(
  parameter  int LANES    = 4,
  parameter  int LANE_LOG = 2,
  parameter  int ADDR_W   = 32,
  parameter  int REG_W    = 6,
  parameter  int DATA_W   = 32,
  parameter  int SPACE_W  = 2,
  parameter  int SIZE_W   = 2,
  localparam int PKT_W    = pktWidth(ADDR_W, REG_W, DATA_W, SPACE_W, SIZE_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      batch_valid_i,
  output logic                      batch_ready_o,
  input  logic                      batch_is_load_i,
  input  logic [LANES-1:0]          batch_mask_i,
  input  logic [LANES*PKT_W-1:0]    batch_pkt_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic                      mem_req_we_o,
  output logic [ADDR_W-1:0]         mem_req_addr_o,
  output logic [DATA_W-1:0]         mem_req_data_o,
  output logic [SPACE_W-1:0]        mem_req_space_o,
  output logic [SIZE_W-1:0]         mem_req_size_o,
  output logic [LANE_LOG-1:0]       mem_req_tag_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [LANE_LOG-1:0]       mem_rsp_tag_i,
  input  logic [DATA_W-1:0]         mem_rsp_data_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [LANES-1:0]          wb_mask_o,
  output logic [REG_W-1:0]          wb_reg_o,
  output logic [LANES*DATA_W-1:0]   wb_data_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int OFF_SPACE = offSpace(SIZE_W);
  localparam int OFF_DATA  = offData(SPACE_W, SIZE_W);
  localparam int OFF_REG   = offReg(DATA_W, SPACE_W, SIZE_W);
  localparam int OFF_ADDR  = offAddr(REG_W, DATA_W, SPACE_W, SIZE_W);

  ldst_state_e state, stateNext;

  logic [LANES*PKT_W-1:0]  pktReg;
  logic [LANES*DATA_W-1:0] dataReg;
  logic [LANES-1:0]        maskReg;
  logic                    isLoadReg;
  logic [LANES-1:0]        pending;
  logic [LANES-1:0]        outstanding;
  logic [LANE_LOG-1:0]     selReg;
  logic                    selValid;
  logic                    errReg;

  logic [LANES-1:0]        pendingNext;
  logic [LANES-1:0]        outNext;
  logic [LANES-1:0]        selOh;
  logic [LANES-1:0]        rspOh;
  logic [LANES-1:0]        issueSet;
  logic [LANE_LOG-1:0]     encIdx;
  logic                    encFound;
  logic [LANE_LOG-1:0]     wbIdx;
  logic                    wbFound;
  logic                    accept;
  logic                    reqFire;
  logic                    rspWindow;
  logic                    rspAccept;
  logic                    reqOn;
  logic                    wbOn;

  assign accept    = (state == ST_IDLE) && batch_valid_i;
  assign reqFire   = (state == ST_ISSUE) && selValid && mem_req_ready_i;
  assign selOh     = LANES'(1) << selReg;
  assign rspOh     = LANES'(1) << mem_rsp_tag_i;
  assign issueSet  = (reqFire && isLoadReg) ? selOh : '0;
  assign rspWindow = (state == ST_ISSUE) || (state == ST_WAIT);

  // A lane being issued this cycle counts as outstanding so its response may land in the same cycle.
  assign rspAccept = mem_rsp_valid_i && rspWindow && |((outstanding | issueSet) & rspOh);
  assign outNext   = (outstanding | issueSet) & ~(rspAccept ? rspOh : '0);

  always_comb begin
    pendingNext = pending;
    if (accept) begin
      pendingNext = batch_mask_i;
    end else if (reqFire) begin
      pendingNext = pending & ~selOh;
    end
  end

  ldst_prio_enc #(.LANES(LANES), .LANE_LOG(LANE_LOG)) uSelEnc (
    .vec   (pendingNext),
    .idx   (encIdx),
    .found (encFound)
  );

  ldst_prio_enc #(.LANES(LANES), .LANE_LOG(LANE_LOG)) uWbEnc (
    .vec   (maskReg),
    .idx   (wbIdx),
    .found (wbFound)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext       = state;
    batch_ready_o   = 1'b0;
    mem_req_valid_o = 1'b0;
    wb_valid_o      = 1'b0;
    busy_o          = 1'b1;
    case (state)
      ST_IDLE: begin
        batch_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (batch_valid_i) begin
          if (batch_mask_i == '0) begin
            stateNext = batch_is_load_i ? ST_WB : ST_IDLE;
          end else begin
            stateNext = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        mem_req_valid_o = selValid;
        if (reqFire && (pendingNext == '0)) begin
          if (!isLoadReg) begin
            stateNext = ST_IDLE;
          end else begin
            stateNext = (outNext == '0) ? ST_WB : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (outNext == '0) begin
          stateNext = ST_WB;
        end
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // The issue lane is registered from next-cycle pending so request fields come straight from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pktReg      <= '0;
      dataReg     <= '0;
      maskReg     <= '0;
      isLoadReg   <= 1'b0;
      pending     <= '0;
      outstanding <= '0;
      selReg      <= '0;
      selValid    <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      pending     <= pendingNext;
      outstanding <= outNext;
      selReg      <= encIdx;
      selValid    <= encFound;
      if (accept) begin
        pktReg    <= batch_pkt_i;
        maskReg   <= batch_mask_i;
        isLoadReg <= batch_is_load_i;
        dataReg   <= '0;
      end
      if (rspAccept) begin
        dataReg[int'(mem_rsp_tag_i)*DATA_W +: DATA_W] <= mem_rsp_data_i;
      end
      if (mem_rsp_valid_i && !rspAccept) begin
        errReg <= 1'b1;
      end
    end
  end

  assign reqOn = (state == ST_ISSUE);
  assign wbOn  = (state == ST_WB);

  assign mem_req_we_o    = reqOn && !isLoadReg;
  assign mem_req_addr_o  = reqOn ? pktReg[int'(selReg)*PKT_W + OFF_ADDR +: ADDR_W] : '0;
  assign mem_req_data_o  = (reqOn && !isLoadReg) ? pktReg[int'(selReg)*PKT_W + OFF_DATA +: DATA_W] : '0;
  assign mem_req_space_o = reqOn ? pktReg[int'(selReg)*PKT_W + OFF_SPACE +: SPACE_W] : '0;
  assign mem_req_size_o  = reqOn ? pktReg[int'(selReg)*PKT_W +: SIZE_W] : '0;
  assign mem_req_tag_o   = reqOn ? selReg : '0;

  assign wb_mask_o = wbOn ? maskReg : '0;
  assign wb_reg_o  = (wbOn && wbFound) ? pktReg[int'(wbIdx)*PKT_W + OFF_REG +: REG_W] : '0;
  assign wb_data_o = wbOn ? dataReg : '0;
  assign err_o     = errReg;

endmodule

// File: tb/tb_ldst_lane_sched.sv
// Directed bench for ldst_lane_sched: a queue-based model of expected requests and
// writebacks is checked every cycle, plus hand-computed latency/data expectations.
module tb_ldst_lane_sched;
  import ldst_pkg::*;

  localparam int LANES = 4, LANE_LOG = 2, ADDR_W = 32, REG_W = 6, DATA_W = 32;
  localparam int SPACE_W = 2, SIZE_W = 2;
  localparam int PKT_W = ADDR_W + REG_W + DATA_W + SPACE_W + SIZE_W;
  localparam int REQ_W = 1 + ADDR_W + DATA_W + SPACE_W + SIZE_W + LANE_LOG;
  localparam int WB_W  = LANES + REG_W + LANES*DATA_W;

  logic clk = 1'b0;
  logic reset;
  logic batch_valid_i, batch_ready_o, batch_is_load_i;
  logic [LANES-1:0] batch_mask_i;
  logic [LANES*PKT_W-1:0] batch_pkt_i;
  logic mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [DATA_W-1:0] mem_req_data_o;
  logic [SPACE_W-1:0] mem_req_space_o;
  logic [SIZE_W-1:0] mem_req_size_o;
  logic [LANE_LOG-1:0] mem_req_tag_o;
  logic mem_rsp_valid_i;
  logic [LANE_LOG-1:0] mem_rsp_tag_i;
  logic [DATA_W-1:0] mem_rsp_data_i;
  logic wb_valid_o, wb_ready_i;
  logic [LANES-1:0] wb_mask_o;
  logic [REG_W-1:0] wb_reg_o;
  logic [LANES*DATA_W-1:0] wb_data_o;
  logic busy_o, err_o;

  ldst_lane_sched dut (
    .clk(clk), .reset(reset),
    .batch_valid_i(batch_valid_i), .batch_ready_o(batch_ready_o),
    .batch_is_load_i(batch_is_load_i), .batch_mask_i(batch_mask_i), .batch_pkt_i(batch_pkt_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_space_o(mem_req_space_o), .mem_req_size_o(mem_req_size_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tag_i(mem_rsp_tag_i), .mem_rsp_data_i(mem_rsp_data_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_mask_o(wb_mask_o),
    .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;
  logic [REQ_W-1:0] expReqQ[$];
  logic [WB_W-1:0] expWbQ[$];
  int rspQ[$];
  logic autoRsp = 1'b0;
  logic [DATA_W-1:0] rspBase = '0;
  logic [LANES*DATA_W-1:0] lastWbData;
  logic [LANES-1:0] lastWbMask;
  logic [REG_W-1:0] lastWbReg;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] laneAddr(input logic [ADDR_W-1:0] base, input int l);
    return base + ADDR_W'(4*l);
  endfunction
  function automatic logic [REG_W-1:0] laneReg(input int l);
    return REG_W'(10 + l);
  endfunction
  function automatic logic [DATA_W-1:0] laneData(input int l);
    return 32'hD000_0000 + DATA_W'(l * 'h11);
  endfunction
  function automatic logic [SPACE_W-1:0] laneSpace(input int l);
    return LDST_SPACE_GLOBAL ^ SPACE_W'(l);
  endfunction
  function automatic logic [SIZE_W-1:0] laneSize(input int l);
    return LDST_SIZE_WORD ^ SIZE_W'(l);
  endfunction

  // Builds the batch, records the expected request order and writeback, then handshakes it.
  task automatic applyStimulus(input logic isLoad, input logic [LANES-1:0] mask,
                               input logic [ADDR_W-1:0] addrBase, input logic [DATA_W-1:0] rspB);
    logic [LANES*PKT_W-1:0] pkts;
    logic [LANES*DATA_W-1:0] wbData;
    logic [REG_W-1:0] wbReg;
    logic [DATA_W-1:0] reqData;
    bit haveReg;
    bit ok;
    pkts = '0; wbData = '0; wbReg = '0; haveReg = 0; ok = 0;
    rspBase = rspB;
    for (int l = 0; l < LANES; l++) begin
      pkts[l*PKT_W +: PKT_W] = {laneAddr(addrBase, l), laneReg(l), laneData(l), laneSpace(l), laneSize(l)};
      if (mask[l]) begin
        reqData = isLoad ? '0 : laneData(l);
        expReqQ.push_back({!isLoad, laneAddr(addrBase, l), reqData, laneSpace(l), laneSize(l), LANE_LOG'(l)});
        if (!haveReg) begin
          wbReg = laneReg(l);
          haveReg = 1;
        end
        wbData[l*DATA_W +: DATA_W] = rspB + DATA_W'(l);
      end
    end
    if (isLoad) expWbQ.push_back({mask, wbReg, wbData});
    batch_valid_i = 1'b1; batch_is_load_i = isLoad; batch_mask_i = mask; batch_pkt_i = pkts;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = batch_ready_o;
      @(posedge clk); #1;
    end
    if (!ok) checkOutput("acceptTimeout", batch_ready_o, 1);
    batch_valid_i = 1'b0; batch_mask_i = '0; batch_pkt_i = '0; batch_is_load_i = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    bit found;
    found = 0; cycles = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      cycles++;
      if (batch_ready_o) found = 1;
      @(posedge clk); #1;
    end
    if (!found) checkOutput("idleTimeout", batch_ready_o, 1);
  endtask

  task automatic waitWb(output int cycles);
    bit found;
    found = 0; cycles = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      cycles++;
      if (wb_valid_o) begin
        found = 1;
        lastWbData = wb_data_o; lastWbMask = wb_mask_o; lastWbReg = wb_reg_o;
      end
      @(posedge clk); #1;
    end
    if (!found) checkOutput("wbTimeout", wb_valid_o, 1);
  endtask

  task automatic waitReqDone();
    bit found;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (!mem_req_valid_o) found = 1;
      @(posedge clk); #1;
    end
    if (!found) checkOutput("issueTimeout", mem_req_valid_o, 0);
  endtask

  // Memory responder: 1-cycle auto responses for load handshakes, or a directed tag queue.
  initial begin
    bit hit;
    logic [LANE_LOG-1:0] hitTag;
    int t;
    mem_rsp_valid_i = 1'b0; mem_rsp_tag_i = '0; mem_rsp_data_i = '0;
    forever begin
      @(negedge clk);
      hit = autoRsp && reset && mem_req_valid_o && mem_req_ready_i && !mem_req_we_o;
      hitTag = mem_req_tag_o;
      @(posedge clk); #2;
      if (hit) begin
        mem_rsp_valid_i = 1'b1; mem_rsp_tag_i = hitTag; mem_rsp_data_i = rspBase + DATA_W'(hitTag);
      end else if (rspQ.size() > 0) begin
        t = rspQ.pop_front();
        mem_rsp_valid_i = 1'b1; mem_rsp_tag_i = LANE_LOG'(t); mem_rsp_data_i = rspBase + DATA_W'(t);
      end else begin
        mem_rsp_valid_i = 1'b0;
      end
    end
  end

  logic [REQ_W-1:0] curReq, reqSnap, expReq;
  logic [WB_W-1:0] expWb;
  bit prevStall = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prevStall = 0;
    end else begin
      curReq = {mem_req_we_o, mem_req_addr_o, mem_req_data_o, mem_req_space_o, mem_req_size_o, mem_req_tag_o};
      if (mem_req_valid_o) begin
        if (prevStall) checkOutput("reqStable", curReq, reqSnap);
        if (mem_req_ready_i) begin
          if (expReqQ.size() == 0) checkOutput("reqWithoutModel", mem_req_valid_o, 0);
          else begin
            expReq = expReqQ.pop_front();
            checkOutput("reqFields", curReq, expReq);
          end
        end
        prevStall = !mem_req_ready_i;
        reqSnap = curReq;
      end else begin
        if (prevStall) checkOutput("reqDropped", mem_req_valid_o, 1);
        prevStall = 0;
      end
      if (wb_valid_o && wb_ready_i) begin
        if (expWbQ.size() == 0) checkOutput("wbWithoutModel", wb_valid_o, 0);
        else begin
          expWb = expWbQ.pop_front();
          checkOutput("wbFields", {wb_mask_o, wb_reg_o, wb_data_o}, expWb);
        end
      end
    end
  end

  initial begin
    int cyc;
    reset = 1'b0; batch_valid_i = 1'b0; batch_is_load_i = 1'b0; batch_mask_i = '0; batch_pkt_i = '0;
    mem_req_ready_i = 1'b1; wb_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstBatchReady", batch_ready_o, 1);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstReqValid", mem_req_valid_o, 0);
    checkOutput("rstWbValid", wb_valid_o, 0);
    checkOutput("rstErr", err_o, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] store batch mask 1011");
    applyStimulus(1'b0, 4'b1011, 32'h200, '0);
    waitIdle(cyc);
    checkOutput("storeIdleCycles", cyc, 4);

    $display("[TB] load batch, out-of-order responses");
    applyStimulus(1'b1, 4'b1111, 32'h100, 32'hA0);
    waitReqDone();
    rspQ.push_back(3); rspQ.push_back(0); rspQ.push_back(2); rspQ.push_back(1);
    waitWb(cyc);
    checkOutput("oooWbData", lastWbData, 128'h000000A3_000000A2_000000A1_000000A0);
    checkOutput("oooWbMask", lastWbMask, 4'hF);
    checkOutput("oooWbReg", lastWbReg, 6'd10);

    $display("[TB] ready stall on lane 1");
    autoRsp = 1'b1;
    applyStimulus(1'b1, 4'b1111, 32'h300, 32'hB0);
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallTag", mem_req_tag_o, 1);
      checkOutput("stallAddr", mem_req_addr_o, 32'h304);
      @(posedge clk); #1;
    end
    mem_req_ready_i = 1'b1;
    waitWb(cyc);
    checkOutput("stallWbData", lastWbData, 128'h000000B3_000000B2_000000B1_000000B0);

    $display("[TB] load latency, two lanes");
    applyStimulus(1'b1, 4'b0101, 32'h400, 32'hD0);
    waitWb(cyc);
    checkOutput("loadLatency", cyc, 4);
    checkOutput("latWbReg", lastWbReg, 6'd10);
    autoRsp = 1'b0;

    $display("[TB] empty load batch");
    applyStimulus(1'b1, 4'b0000, 32'h500, 32'hE0);
    waitWb(cyc);
    checkOutput("emptyWbCycles", cyc, 1);
    checkOutput("emptyWbMask", lastWbMask, 4'h0);

    $display("[TB] response in same cycle as its request");
    applyStimulus(1'b1, 4'b0001, 32'h600, 32'hC0);
    rspQ.push_back(0);
    waitWb(cyc);
    checkOutput("sameCycleWb", cyc, 2);
    checkOutput("sameCycleData", lastWbData, 128'h000000C0);
    checkOutput("sameCycleNoErr", err_o, 0);

    $display("[TB] stray response while idle");
    rspQ.push_back(2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("strayErr", err_o, 1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'b0110, 32'h700, '0);
    waitIdle(cyc);
    checkOutput("afterStrayIdle", cyc, 3);
    checkOutput("errSticky", err_o, 1);

    $display("[TB] reset while waiting on two lanes");
    applyStimulus(1'b1, 4'b1001, 32'h800, 32'hF0);
    waitReqDone();
    checkOutput("waitBusy", busy_o, 1);
    reset = 1'b0;
    expReqQ.delete();
    expWbQ.delete();
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midRstReady", batch_ready_o, 1);
    checkOutput("midRstBusy", busy_o, 0);
    checkOutput("midRstErr", err_o, 0);
    checkOutput("midRstWb", wb_valid_o, 0);
    checkOutput("midRstReq", mem_req_valid_o, 0);
    checkOutput("midRstWbData", wb_data_o, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reqQueueDrained", expReqQ.size(), 0);
    checkOutput("wbQueueDrained", expWbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
